// File: rtl/lcd_timing_gen_if.sv
// lcd_timing_gen_if: pixel request/data bus between the timing generator and its pixel source.
interface lcd_timing_gen_if;
   logic        req;
   logic [11:0] req_x;
   logic [11:0] req_y;
   logic        frame_start;
   logic [23:0] pix_data;
   modport master (output req, req_x, req_y, frame_start, input pix_data);
   modport slave (input req, req_x, req_y, frame_start, output pix_data);
endinterface

// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: RGB parallel-LCD timing generator with request-ahead pixel fetch and built-in patterns.
module lcd_timing_gen #(
   parameter int H_ACTIVE = 800,
   parameter int H_FP     = 40,
   parameter int H_SYNC   = 128,
   parameter int H_BP     = 88,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 1,
   parameter int V_SYNC   = 3,
   parameter int V_BP     = 21,
   parameter int HS_POL   = 0,
   parameter int VS_POL   = 0,
   parameter int DATA_LAT = 1,
   parameter int R_W      = 5,
   parameter int G_W      = 6,
   parameter int B_W      = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   lcd_timing_gen_if.master pix,
   input  logic [1:0]       mode,
   input  logic [23:0]      solid_rgb,
   output logic             lcd_clk,
   output logic             lcd_hs,
   output logic             lcd_vs,
   output logic             lcd_de,
   output logic [R_W-1:0]   lcd_r,
   output logic [G_W-1:0]   lcd_g,
   output logic [B_W-1:0]   lcd_b
);
   localparam logic [11:0] H_LAST   = 12'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
   localparam logic [11:0] V_LAST   = 12'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);
   localparam logic [11:0] H_ST     = 12'(H_SYNC + H_BP);
   localparam logic [11:0] V_ST     = 12'(V_SYNC + V_BP);
   localparam logic [11:0] H_END    = 12'(H_SYNC + H_BP + H_ACTIVE);
   localparam logic [11:0] V_END    = 12'(V_SYNC + V_BP + V_ACTIVE);
   localparam logic [11:0] HS_W     = 12'(H_SYNC);
   localparam logic [11:0] VS_W     = 12'(V_SYNC);
   localparam logic [11:0] X_LAST   = 12'(H_ACTIVE - 1);
   localparam logic [11:0] Y_LAST   = 12'(V_ACTIVE - 1);
   localparam logic [11:0] BAR_LAST = 12'((H_ACTIVE >= 8 ? H_ACTIVE / 8 : 1) - 1);
   localparam logic        HSP      = 1'(HS_POL);
   localparam logic        VSP      = 1'(VS_POL);

   logic [11:0] h_cnt, v_cnt, x0, y0, bcnt;
   logic [2:0]  bar0;
   logic [1:0]  mode_q;
   logic        act, req0, hs0, vs0, fs0;
   logic [29:0] st0, d;
   logic [23:0] bar_rgb, sel, rgb;
   logic        grid_on;

   assign act = h_cnt >= H_ST && h_cnt < H_END && v_cnt >= V_ST && v_cnt < V_END;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt  <= '0;
         v_cnt  <= '0;
         x0     <= '0;
         y0     <= '0;
         bcnt   <= '0;
         bar0   <= '0;
         req0   <= 1'b0;
         hs0    <= 1'b0;
         vs0    <= 1'b0;
         fs0    <= 1'b0;
         mode_q <= '0;
      end else begin
         h_cnt <= h_cnt == H_LAST ? '0 : h_cnt + 12'd1;
         if (h_cnt == H_LAST) v_cnt <= v_cnt == V_LAST ? '0 : v_cnt + 12'd1;
         req0 <= act;
         hs0  <= h_cnt < HS_W;
         vs0  <= v_cnt < VS_W;
         fs0  <= h_cnt == '0 && v_cnt == '0;
         if (fs0) mode_q <= mode;
         if (act) begin
            x0 <= h_cnt - H_ST;
            y0 <= v_cnt - V_ST;
            // Bar index advances every BAR_W pixels; saturating at black covers the remainder.
            if (h_cnt == H_ST) begin
               bar0 <= '0;
               bcnt <= '0;
            end else if (bcnt == BAR_LAST) begin
               bcnt <= '0;
               if (bar0 != 3'd7) bar0 <= bar0 + 3'd1;
            end else begin
               bcnt <= bcnt + 12'd1;
            end
         end
      end
   end

   assign st0 = {hs0, vs0, req0, bar0, y0, x0};

   if (DATA_LAT == 0) begin : g_lat0
      assign d = st0;
   end else begin : g_lat
      logic [29:0] dly [DATA_LAT];
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int i = 0; i < DATA_LAT; i++) dly[i] <= '0;
         end else begin
            dly[0] <= st0;
            for (int i = 1; i < DATA_LAT; i++) dly[i] <= dly[i-1];
         end
      end
      assign d = dly[DATA_LAT-1];
   end

   // Bar colours white..black map onto inverted index bits: r=~b1, g=~b2, b=~b0.
   always_comb begin
      bar_rgb = {{8{~d[25]}}, {8{~d[26]}}, {8{~d[24]}}};
      grid_on = d[3:0] == 4'd0 || d[15:12] == 4'd0 || d[11:0] == X_LAST || d[23:12] == Y_LAST;
      sel     = mode_q == 2'd0 ? pix.pix_data : mode_q == 2'd1 ? bar_rgb :
                mode_q == 2'd2 ? {24{grid_on}} : solid_rgb;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lcd_hs <= ~HSP;
         lcd_vs <= ~VSP;
         lcd_de <= 1'b0;
         rgb    <= '0;
      end else begin
         lcd_hs <= d[29] ? HSP : ~HSP;
         lcd_vs <= d[28] ? VSP : ~VSP;
         lcd_de <= d[27];
         rgb    <= d[27] ? sel : '0;
      end
   end

   assign pix.req         = req0;
   assign pix.req_x       = x0;
   assign pix.req_y       = y0;
   assign pix.frame_start = fs0;
   assign lcd_clk         = ~clk;
   assign lcd_r           = rgb[23 -: R_W];
   assign lcd_g           = rgb[15 -: G_W];
   assign lcd_b           = rgb[7 -: B_W];
endmodule

// File: tb/tb_lcd_timing_gen.sv
// tb_lcd_timing_gen: random-mode run of lcd_timing_gen against a position-based frame model.
module tb_lcd_timing_gen;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic [23:0] solid_rgb = 24'd0;
   logic        lcd_clk, lcd_hs, lcd_vs, lcd_de;
   logic [4:0]  lcd_r, lcd_b;
   logic [5:0]  lcd_g;

   lcd_timing_gen_if pix();

   lcd_timing_gen #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(0), .VS_POL(0), .DATA_LAT(2), .R_W(5), .G_W(6), .B_W(5)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pix(pix), .mode(mode), .solid_rgb(solid_rgb),
      .lcd_clk(lcd_clk), .lcd_hs(lcd_hs), .lcd_vs(lcd_vs), .lcd_de(lcd_de),
      .lcd_r(lcd_r), .lcd_g(lcd_g), .lcd_b(lcd_b)
   );

   always #5 clk = ~clk;

   int          n_chk = 0, n_fail = 0, k = 0, de_cnt = 0;
   int          fmode [16];
   int          plan [7];
   logic [23:0] sol_at [2048];
   logic [23:0] key, q0, q1;
   logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s k=%0d got=%h exp=%h", tag, k, got, exp);
      end
   endtask

   // External source content for a coordinate, spread so it survives 565 truncation.
   function automatic logic [23:0] ext(input logic [11:0] x, input logic [11:0] y);
      logic [4:0] s;
      s = 5'(x + y);
      return {y[4:0], 3'b0, x[5:0], 2'b0, s, 3'b0} ^ key;
   endfunction

   // Frame of 23x7: sync 3/1, back porch 2/1, active from h=5, v=2.
   task automatic pos(input int n, output int h, output int v, output logic act);
      int p;
      p   = n % 161;
      h   = p % 23;
      v   = p / 23;
      act = h >= 5 && h < 21 && v >= 2 && v < 6;
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_req"}, 32'(pix.req), 0);
      chk({tag, "_fs"}, 32'(pix.frame_start), 0);
      chk({tag, "_req_x"}, 32'(pix.req_x), 0);
      chk({tag, "_req_y"}, 32'(pix.req_y), 0);
      chk({tag, "_hs"}, 32'(lcd_hs), 1);
      chk({tag, "_vs"}, 32'(lcd_vs), 1);
      chk({tag, "_de"}, 32'(lcd_de), 0);
      chk({tag, "_rgb"}, 32'({lcd_r, lcd_g, lcd_b}), 0);
   endtask

   task automatic check_cycle();
      int h, v, q, m, x, y;
      logic act, e_hs, e_vs, e_de;
      logic [23:0] e_rgb;
      if (k == 0) begin
         check_reset("rel");
         return;
      end
      pos(k - 1, h, v, act);
      chk("req", 32'(pix.req), 32'(act));
      chk("frame_start", 32'(pix.frame_start), 32'((k - 1) % 161 == 0));
      if (act) begin
         chk("req_x", 32'(pix.req_x), 32'(h - 5));
         chk("req_y", 32'(pix.req_y), 32'(v - 2));
      end
      e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_rgb = '0;
      if (k >= 4) begin
         q = k - 4;
         pos(q, h, v, act);
         e_hs = h >= 3;
         e_vs = v >= 1;
         e_de = act;
         if (act) begin
            m = fmode[q / 161];
            x = h - 5;
            y = v - 2;
            e_rgb = m == 0 ? ext(12'(x), 12'(y)) : m == 1 ? bars[x / 2 > 7 ? 7 : x / 2] :
                    m == 2 ? {24{x % 16 == 0 || y % 16 == 0 || x == 15 || y == 3}} : sol_at[k - 1];
         end
      end
      chk("lcd_hs", 32'(lcd_hs), 32'(e_hs));
      chk("lcd_vs", 32'(lcd_vs), 32'(e_vs));
      chk("lcd_de", 32'(lcd_de), 32'(e_de));
      chk("lcd_r", 32'(lcd_r), 32'(e_rgb[23:19]));
      chk("lcd_g", 32'(lcd_g), 32'(e_rgb[15:10]));
      chk("lcd_b", 32'(lcd_b), 32'(e_rgb[7:3]));
   endtask

   task automatic drive(input bit phase_a);
      pix.pix_data = q1;
      q1 = q0;
      q0 = pix.req ? ext(pix.req_x, pix.req_y) : 24'h0;
      if (k % 161 == 80) mode = phase_a ? 2'(plan[k / 161]) : 2'($urandom_range(0, 3));
      solid_rgb = (phase_a && k / 161 == 5) ? 24'h804020 : 24'($urandom);
      sol_at[k] = solid_rgb;
   endtask

   task automatic run(input int ncyc, input bit phase_a);
      rst_n = 1'b1;
      k = 0; q0 = '0; q1 = '0; de_cnt = 0;
      check_cycle();
      drive(phase_a);
      repeat (ncyc) begin
         @(posedge clk);
         @(negedge clk);
         k++;
         if (k % 161 == 1) fmode[k / 161] = int'(mode);
         check_cycle();
         if (k > 4 && (k - 4) % 161 == 0) begin
            chk("de_per_frame", 32'(de_cnt), 64);
            de_cnt = 0;
         end
         if (lcd_de) de_cnt++;
         drive(phase_a);
      end
   endtask

   initial begin
      key = 24'($urandom);
      pix.pix_data = '0;
      plan = '{1, 0, 2, 3, 3, 0, 0};
      plan[5] = int'($urandom_range(0, 3));
      plan[6] = int'($urandom_range(0, 3));
      repeat (3) @(negedge clk);
      check_reset("por");
      // Ends in the cycle where the counters sit at v=2, h=9 of frame 7.
      run(7 * 161 + 55, 1'b1);
      rst_n = 1'b0;
      #1;
      check_reset("async");
      repeat (2) @(negedge clk);
      check_reset("held");
      run(3 * 161 + 10, 1'b0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/lcd_timing_gen.md
Name: lcd_timing_gen

Overview:
- Parametrised RGB parallel-LCD timing generator with a built-in pattern source; successor to the fixed 800x480 controller/data pair.
- Generates HSYNC, VSYNC and DE with programmable porches and sync polarity.
- Issues pixel requests with coordinates ahead of DE by a programmable pixel-source latency, so the source's data, DE and syncs leave aligned.
- Muxes the external pixel data with internal colorbar and grid patterns, then truncates RGB888 to the panel width.
- Sits between the pixel PLL output and the panel pins.

Parameters:
H_ACTIVE, 800, active pixels per line
H_FP, 40, horizontal front porch (clocks)
H_SYNC, 128, HSYNC width (clocks)
H_BP, 88, horizontal back porch (clocks)
V_ACTIVE, 480, active lines per frame
V_FP, 1, vertical front porch (lines)
V_SYNC, 3, VSYNC width (lines)
V_BP, 21, vertical back porch (lines)
HS_POL, 0, HSYNC active level
VS_POL, 0, VSYNC active level
DATA_LAT, 1, clocks from req to valid pix_data (range 0..4)
R_W / G_W / B_W, 5 / 6 / 5, panel colour widths (each 1..8)

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
mode  in  2  0 external, 1 colorbar, 2 grid, 3 solid
solid_rgb  in  24  RGB888 colour for mode 3
pix_data  in  24  RGB888 from the external source, valid DATA_LAT clocks after req
req  out  1  pixel request (stage 0)
req_x  out  12  requested column, 0..H_ACTIVE-1
req_y  out  12  requested row, 0..V_ACTIVE-1
frame_start  out  1  one-clock pulse at h_cnt=0, v_cnt=0 (stage 0)
lcd_clk  out  1  inverted clk
lcd_hs  out  1  HSYNC
lcd_vs  out  1  VSYNC
lcd_de  out  1  data enable
lcd_r / lcd_g / lcd_b  out  R_W / G_W / B_W  panel colour

Behaviour:
Interface and reset:
- One clock. Reset is asynchronous and active-low, on port rst_n. clk is the clock.
- Reset values: h_cnt=0, v_cnt=0, req=0, req_x=0, req_y=0, frame_start=0, lcd_de=0, lcd_rgb=0, lcd_hs=~HS_POL, lcd_vs=~VS_POL, mode_q=0, all pipeline stages inactive.

Counters:
- H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP. V_TOTAL is built the same way from the V_ parameters.
- h_cnt runs 0..H_TOTAL-1 and wraps to 0. v_cnt increments when h_cnt wraps and itself wraps at V_TOTAL-1.
- Segment order within a line is sync, back porch, active, front porch. The same order applies vertically.

Stage 0 (combinational from the counters, registered once into the req outputs):
- hs_raw while h_cnt < H_SYNC. vs_raw while v_cnt < V_SYNC.
- act when h_cnt is in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) and v_cnt is in the matching vertical window.
- req=act. req_x = h_cnt-(H_SYNC+H_BP), req_y = v_cnt-(V_SYNC+V_BP); both hold their last value when act=0.

Alignment:
- hs, vs and act are delayed through DATA_LAT register stages.
- Output registers capture the delayed signals together with the selected colour.
- A pixel requested at cycle t appears on the lcd_* outputs at cycle t+DATA_LAT+1. This is fixed latency with no back-pressure.

Mode selection:
- mode is sampled into mode_q only on frame_start. Mid-frame mode changes take effect at the next frame.

Patterns (computed from pipelined req_x/req_y so they stay aligned with pix_data):
- Colorbar: 8 vertical bars, BAR_W = H_ACTIVE/8 (elaboration constant).
  - Order: white, yellow, cyan, green, magenta, red, blue, black.
  - Bar index comes from a counter: reset on req_x=0, advanced every BAR_W pixels, saturating at 7. No run-time divider.
  - Remainder pixels stay black.
- Grid: white when req_x[3:0]==0, req_y[3:0]==0, req_x==H_ACTIVE-1 or req_y==V_ACTIVE-1; otherwise black.
- Solid: solid_rgb, sampled every pixel.

Output formatting:
- When the delayed act=0, lcd_rgb is 0.
- Truncation takes the MSBs: lcd_r = rgb[23 -: R_W], lcd_g = rgb[15 -: G_W], lcd_b = rgb[7 -: B_W].
- Sync outputs are driven at HS_POL/VS_POL when active, and at the inverse otherwise.

Boundary conditions:
- Reset asserted mid-frame clears everything immediately. After release, the first cycle is h=0, v=0 with frame_start=1.
- DATA_LAT=0 makes the pipeline one stage deep.

Test Plan:
Use sim parameters H 16/2/3/2 (H_TOTAL 23), V 4/1/1/1 (V_TOTAL 7), DATA_LAT=2, pols 0.
1. Reset release -> frame_start high on the first clock. lcd_hs low for 3 clks every 23. lcd_vs low for 23 clks every 161. lcd_de high 16 clks/line on 4 lines per frame.
2. Mode 0, source returns pix_data = {req_y,req_x} packed, 2 clks late -> every DE cycle shows the matching coordinate. The first DE rises exactly 3 clks after the first req.
3. Mode 1, H_ACTIVE=16 -> bars 2 px wide: x0-1 white (r=1F,g=3F,b=1F), x14-15 black, x10-11 red (1F,0,0).
4. Mode changed 0->2 mid-frame -> output stays external until the next frame_start. Then grid: x=0 and x=15 white, x=5 black on row 2, row 0 all white.
5. Mode 3 with solid_rgb=0x804020 -> lcd_r=0x10, lcd_g=0x10, lcd_b=0x04. In blanking, rgb=0.
6. rst_n pulsed low at v=2, h=9 -> outputs take their reset values asynchronously. After release the timing restarts at h=0, v=0 with frame_start.
